// File: rtl/blinky_pkg.sv
// Shared constants and helpers for the blinky LED driver.
// Holds the divider counter-width function and the PWM counter width.
package blinky_pkg;

    // Width of the optional dimming PWM counter (256 steps).
    localparam int PWM_W = 8;

    // Counter width for a terminal count of n: max(1, clog2(n)).
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/blinky_if.sv
// LED drive bundle between the blinky core and the pad / observer.
// Ports: led (master drives, slave observes).
interface blinky_if;
    logic led;

    modport master (output led);
    modport slave  (input  led);
endinterface

// File: rtl/blinky_div.sv
// Terminal-count clock divider: cnt runs 0..DIV-1 and wraps.
// Ports: clk, rst (sync, active-high), tick (high while cnt == DIV-1).
module blinky_div
    import blinky_pkg::*;
#(
    parameter int DIV = 13_500_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int           W    = cnt_width(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    // Power-up value matches reset so the block runs with rst tied low.
    logic [W-1:0] cnt = '0;

    // Wrap on equality only, so cnt never exceeds LAST.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    // tick comes straight off the register; the edge that wraps
    // cnt is the same edge on which the consumer acts on tick.
    assign tick = (cnt == LAST);

endmodule

// File: rtl/blinky.sv
// LED blinker: toggles a blink state every DIV clocks and drives a
// registered LED with selectable polarity.
// Ports: sys_clk, sys_rst (sync, active-high), io.led (registered).
// Optional BLINKY_DIM_EN adds an 8-bit PWM that dims the on-phase
// to DIM_DUTY/256; without it the PWM logic is absent.
module blinky
    import blinky_pkg::*;
#(
    parameter int DIV        = 13_500_000,
    parameter bit ACTIVE_LOW = 1'b0,
    parameter int DIM_DUTY   = 64
) (
    input  logic     sys_clk,
    input  logic     sys_rst,
    blinky_if.master io
);

    if (DIV < 1) begin : g_div_chk
        $error("blinky: DIV must be >= 1");
    end

    if (DIM_DUTY < 0 || DIM_DUTY > 255) begin : g_duty_chk
        $error("blinky: DIM_DUTY must be in 0..255");
    end

    logic tick;
    logic blink_d;
    logic on_d;

    // Power-up values equal reset values (LED off).
    logic blink = 1'b0;
    logic led_q = ACTIVE_LOW;

    blinky_div #(
        .DIV (DIV)
    ) u_div (
        .clk  (sys_clk),
        .rst  (sys_rst),
        .tick (tick)
    );

    assign blink_d = blink ^ tick;

`ifdef BLINKY_DIM_EN
    localparam logic [PWM_W:0] DUTY = (PWM_W + 1)'(DIM_DUTY);

    logic [PWM_W-1:0] pwm_cnt = '0;
    logic [PWM_W-1:0] pwm_d;

    assign pwm_d = pwm_cnt + PWM_W'(1);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_d;
        end
    end

    // Gate with the next PWM value so led_q and pwm_cnt stay aligned.
    assign on_d = blink_d && ({1'b0, pwm_d} < DUTY);
`else
    assign on_d = blink_d;
`endif

    // led_q is updated from next-state values so the LED changes on
    // the same edge as the blink state, with no extra latency.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            blink <= 1'b0;
            led_q <= ACTIVE_LOW;
        end else begin
            blink <= blink_d;
            led_q <= on_d ^ ACTIVE_LOW;
        end
    end

    assign io.led = led_q;

endmodule

// File: tb/tb_blinky.sv
// Self-checking bench for blinky: several parameterisations side by
// side, expected LED levels queued per edge and compared after it.
module tb_blinky;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

`ifdef BLINKY_DIM_EN
    localparam int N = 6;
`else
    localparam int N = 4;
`endif

    // 0: DIV5, 1: DIV1, 2: DIV5 active-low, 3: DIV5 rst tied low
    // 4: DIV512 duty64, 5: DIV512 duty0 (dim build only)
    int divs   [N];
    int als    [N];
    int duties [N];
    int k      [N];

    blinky_if if_a ();
    blinky_if if_b ();
    blinky_if if_c ();
    blinky_if if_d ();

    blinky #(.DIV(5), .ACTIVE_LOW(1'b0)) u_a (
        .sys_clk (clk), .sys_rst (rst), .io (if_a));
    blinky #(.DIV(1), .ACTIVE_LOW(1'b0)) u_b (
        .sys_clk (clk), .sys_rst (rst), .io (if_b));
    blinky #(.DIV(5), .ACTIVE_LOW(1'b1)) u_c (
        .sys_clk (clk), .sys_rst (rst), .io (if_c));
    blinky #(.DIV(5), .ACTIVE_LOW(1'b0)) u_d (
        .sys_clk (clk), .sys_rst (1'b0), .io (if_d));

`ifdef BLINKY_DIM_EN
    blinky_if if_e ();
    blinky_if if_f ();

    blinky #(.DIV(512), .DIM_DUTY(64)) u_e (
        .sys_clk (clk), .sys_rst (rst), .io (if_e));
    blinky #(.DIV(512), .DIM_DUTY(0)) u_f (
        .sys_clk (clk), .sys_rst (rst), .io (if_f));
`endif

    typedef struct {
        int   id;
        int   kk;
        logic exp;
    } exp_t;

    exp_t sbq[$];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic obs(input int id);
        case (id)
            0: return if_a.led;
            1: return if_b.led;
            2: return if_c.led;
            3: return if_d.led;
`ifdef BLINKY_DIM_EN
            4: return if_e.led;
            5: return if_f.led;
`endif
            default: return 1'bx;
        endcase
    endfunction

    // Reference: after the k-th free-running edge the blink state is
    // the parity of the number of completed DIV-clock intervals.
    function automatic logic model(input int id, input int kk);
        logic on;
        on = ((kk / divs[id]) % 2) == 1;
`ifdef BLINKY_DIM_EN
        on = on && ((kk % 256) < duties[id]);
`endif
        return on ^ als[id][0];
    endfunction

    // Drive rst for one edge, queue expectations, check after edge.
    task automatic step(input logic r);
        exp_t e;
        rst = r;
        for (int i = 0; i < N; i++) begin
            if (r && i != 3) begin
                k[i] = 0;
                e = '{id: i, kk: 0, exp: als[i][0]};
            end else begin
                k[i] = k[i] + 1;
                e = '{id: i, kk: k[i], exp: model(i, k[i])};
            end
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk($sformatf("led%0d_k%0d", e.id, e.kk),
                int'(obs(e.id)), int'(e.exp));
        end
    endtask

    initial begin
        int   toggles;
        logic prev;

        divs[0] = 5; als[0] = 0; duties[0] = 64;
        divs[1] = 1; als[1] = 0; duties[1] = 64;
        divs[2] = 5; als[2] = 1; duties[2] = 64;
        divs[3] = 5; als[3] = 0; duties[3] = 64;
`ifdef BLINKY_DIM_EN
        divs[4] = 512; als[4] = 0; duties[4] = 64;
        divs[5] = 512; als[5] = 0; duties[5] = 0;
`endif
        for (int i = 0; i < N; i++) k[i] = 0;

        // Power-up values before any clock edge.
        #1;
        chk("powerup_tied", int'(if_d.led), 0);
        chk("powerup_al", int'(if_c.led), 1);

        step(1'b1);
        step(1'b1);

        toggles = 0;
        prev    = if_a.led;
        for (int c = 0; c < 30; c++) begin
            step(1'b0);
            if (if_a.led != prev) toggles++;
            prev = if_a.led;
        end
        chk("toggles_30clk", toggles, 6);

        // Three more edges leave the DIV=5 divider at count 3.
        for (int c = 0; c < 3; c++) step(1'b0);
        step(1'b1);
        for (int c = 0; c < 12; c++) step(1'b0);

`ifdef BLINKY_DIM_EN
        step(1'b1);
        for (int c = 0; c < 1100; c++) step(1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
